brick_sort_seq: RTL



---
 rtl/brick_sort_seq.sv | 130 +++++++++++++
 1 files changed

// File: rtl/brick_sort_seq.sv
// Sequential odd-even transposition sorter: loads N words serially, sorts them in N
// single-rank phases over a register file, then drains them in ascending unsigned order.
module brick_sort_seq #(
    parameter int LOG_INPUT_NUM = 4,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);

    localparam int N = 1 << LOG_INPUT_NUM;
    localparam logic [LOG_INPUT_NUM-1:0] LAST_IDX = LOG_INPUT_NUM'(N - 1);
    localparam logic [LOG_INPUT_NUM-1:0] IDX_ONE  = LOG_INPUT_NUM'(1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                   state_reg, state_next;
    logic [LOG_INPUT_NUM-1:0] wr_idx_reg, wr_idx_next;
    logic [LOG_INPUT_NUM-1:0] rd_idx_reg, rd_idx_next;
    logic [LOG_INPUT_NUM-1:0] phase_reg, phase_next;
    logic [DATA_WIDTH-1:0]    mem_reg [N];
    logic [DATA_WIDTH-1:0]    sorted  [N];
    logic                     load_fire;

    // One rank of compare-exchange elements; phase parity picks the pairing.
    // Each slot computes its own result so the rank is a pure per-slot mux.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cx
            logic [DATA_WIDTH-1:0] even_val;
            logic [DATA_WIDTH-1:0] odd_val;
            if ((gi % 2) == 0) begin : g_even_slot
                assign even_val = (mem_reg[gi] > mem_reg[gi+1]) ? mem_reg[gi+1] : mem_reg[gi];
                if (gi == 0) begin : g_edge
                    assign odd_val = mem_reg[gi];
                end else begin : g_pair
                    assign odd_val = (mem_reg[gi-1] > mem_reg[gi]) ? mem_reg[gi-1] : mem_reg[gi];
                end
            end else begin : g_odd_slot
                assign even_val = (mem_reg[gi-1] > mem_reg[gi]) ? mem_reg[gi-1] : mem_reg[gi];
                if (gi == N - 1) begin : g_edge
                    assign odd_val = mem_reg[gi];
                end else begin : g_pair
                    assign odd_val = (mem_reg[gi] > mem_reg[gi+1]) ? mem_reg[gi+1] : mem_reg[gi];
                end
            end
            assign sorted[gi] = phase_reg[0] ? odd_val : even_val;
        end
    endgenerate

    assign in_ready  = (state_reg == ST_LOAD);
    assign out_valid = (state_reg == ST_DRAIN);
    assign busy      = (state_reg != ST_LOAD);
    assign out_last  = (state_reg == ST_DRAIN) && (rd_idx_reg == LAST_IDX);
    assign out_data  = mem_reg[rd_idx_reg];
    assign load_fire = in_valid && in_ready;

    always_comb begin
        state_next  = state_reg;
        wr_idx_next = wr_idx_reg;
        rd_idx_next = rd_idx_reg;
        phase_next  = phase_reg;
        case (state_reg)
            ST_LOAD: begin
                if (load_fire) begin
                    wr_idx_next = wr_idx_reg + IDX_ONE;
                    if (wr_idx_reg == LAST_IDX) begin
                        phase_next = '0;
                        state_next = ST_SORT;
                    end
                end
            end
            ST_SORT: begin
                phase_next = phase_reg + IDX_ONE;
                if (phase_reg == LAST_IDX) begin
                    rd_idx_next = '0;
                    state_next  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    rd_idx_next = rd_idx_reg + IDX_ONE;
                    if (rd_idx_reg == LAST_IDX) begin
                        state_next = ST_LOAD;
                    end
                end
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_LOAD;
            wr_idx_reg <= '0;
            rd_idx_reg <= '0;
            phase_reg  <= '0;
            for (int i = 0; i < N; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            state_reg  <= state_next;
            wr_idx_reg <= wr_idx_next;
            rd_idx_reg <= rd_idx_next;
            phase_reg  <= phase_next;
            if (state_reg == ST_SORT) begin
                for (int i = 0; i < N; i++) begin
                    mem_reg[i] <= sorted[i];
                end
            end else if (load_fire) begin
                mem_reg[wr_idx_reg] <= in_data;
            end
        end
    end

endmodule
